// File: rtl/i2c_sched_pkg.sv
// i2c_sched_pkg: shared state encoding and index/select constants for the I2C scheduler
package i2c_sched_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;
    localparam logic REQ0       = 1'b0;
    localparam logic REQ1       = 1'b1;
    localparam logic SEL_SLAVE1 = 1'b0;
    localparam logic SEL_SLAVE2 = 1'b1;
endpackage

// File: rtl/i2c_rr_arbiter2.sv
// i2c_rr_arbiter2: combinational two-way round-robin pick
module i2c_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] win,
    output logic       valid
);
    import i2c_sched_pkg::*;
    // a lone requester wins outright; on contention the pointer names the winner
    always_comb begin
        win   = (req == 2'b11) ? ((rr_ptr == REQ1) ? 2'b10 : 2'b01) : req;
        valid = |req;
    end
endmodule

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: arbitrates two requesters onto one I2C master and returns status/read data
module i2c_txn_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_W      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] req_rw,
    input  logic [1:0] req_sel,
    input  logic [7:0] req_wdata0,
    input  logic [7:0] req_wdata1,
    output logic [1:0] gnt,
    output logic [1:0] rsp_valid,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       m_start,
    output logic       m_rw,
    output logic       m_slave_sel,
    output logic [7:0] m_wdata,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_nack,
    input  logic [7:0] m_rdata,
    output logic       busy
);
    import i2c_sched_pkg::*;
    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 rr_ptr, winner, win_valid, timeout;
    logic [1:0]           win, gnt_n, rsp_valid_n;
    logic                 m_start_n, rsp_err_n;
    logic [7:0]           rsp_rdata_n;
    i2c_rr_arbiter2 u_arb (.req(req), .rr_ptr(rr_ptr), .win(win), .valid(win_valid));
    assign timeout = (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    // next state plus the next value of every registered pulse/response output
    always_comb begin
        state_n     = state;
        gnt_n       = 2'b00;
        m_start_n   = 1'b0;
        rsp_valid_n = 2'b00;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = 8'h00;
        case (state)
            ST_IDLE: if (!m_busy && win_valid) begin
                state_n   = ST_ISSUE;
                gnt_n     = win;
                m_start_n = 1'b1;
            end
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT: if (m_done || timeout) begin
                state_n     = ST_RESP;
                rsp_valid_n = (winner == REQ1) ? 2'b10 : 2'b01;
                rsp_err_n   = m_done ? m_nack : 1'b1;
                rsp_rdata_n = (m_done && m_rw) ? m_rdata : 8'h00;
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end
    // registered outputs, latched request fields, timeout counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt         <= 2'b00;
            m_start     <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_err     <= 1'b0;
            rsp_rdata   <= 8'h00;
            busy        <= 1'b0;
            winner      <= REQ0;
            m_rw        <= 1'b0;
            m_slave_sel <= SEL_SLAVE1;
            m_wdata     <= 8'h00;
            cnt         <= '0;
            rr_ptr      <= REQ0;
        end else begin
            gnt       <= gnt_n;
            m_start   <= m_start_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
            busy      <= (state_n != ST_IDLE);
            if (m_start_n) begin
                winner      <= win[1];
                m_rw        <= win[1] ? req_rw[1] : req_rw[0];
                m_slave_sel <= win[1] ? req_sel[1] : req_sel[0];
                m_wdata     <= win[1] ? req_wdata1 : req_wdata0;
            end
            if (state == ST_ISSUE) begin
                cnt    <= '0;
                rr_ptr <= ~winner;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb_i2c_txn_scheduler: randomized self-checking bench with a transaction-level reference model
module tb_i2c_txn_scheduler;
    localparam int T = 16;
    logic       clk = 1'b0, reset = 1'b1;
    logic [1:0] req = '0, req_rw = '0, req_sel = '0;
    logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0] gnt, rsp_valid;
    logic       rsp_err, m_start, m_rw, m_slave_sel, busy;
    logic [7:0] rsp_rdata, m_wdata;
    logic       m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
    logic [7:0] m_rdata = '0;
    int         n_tests = 0, n_fail = 0;
    logic       ptr = 1'b0;

    i2c_txn_scheduler #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_sel(req_sel),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .m_start(m_start), .m_rw(m_rw),
        .m_slave_sel(m_slave_sel), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
        .m_nack(m_nack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full transaction; d = WAIT cycle index of m_done (0..T-1) or -1 for none
    task automatic run_txn(input logic [1:0] r, input logic [1:0] rw, input logic [1:0] sel,
                           input logic [7:0] w0, input logic [7:0] w1, input int d,
                           input logic nack, input logic [7:0] rd, input bit keep, input string tag);
        logic       idx, e_rw, e_sel, e_err, bad;
        logic [1:0] oh;
        logic [7:0] e_w, e_rd;
        int         k;
        idx   = (r == 2'b11) ? ptr : r[1];
        oh    = idx ? 2'b10 : 2'b01;
        e_rw  = rw[idx];
        e_sel = sel[idx];
        e_w   = idx ? w1 : w0;
        e_err = (d < 0) ? 1'b1 : nack;
        e_rd  = (d < 0 || !e_rw) ? 8'h00 : rd;
        k     = (d < 0) ? T + 1 : d + 2;
        req = r; req_rw = rw; req_sel = sel; req_wdata0 = w0; req_wdata1 = w1;
        tick();
        n_tests++;
        if (gnt !== oh || m_start !== 1'b1 || m_rw !== e_rw || m_slave_sel !== e_sel || m_wdata !== e_w || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s grant: gnt=%b start=%b rw=%b sel=%b wdata=%h busy=%b, want gnt=%b start=1 rw=%b sel=%b wdata=%h busy=1",
                     tag, gnt, m_start, m_rw, m_slave_sel, m_wdata, busy, oh, e_rw, e_sel, e_w);
        end
        ptr = ~idx;
        if (!keep) req[idx] = 1'b0;
        req_rw = 2'($urandom); req_sel = 2'($urandom);
        req_wdata0 = 8'($urandom); req_wdata1 = 8'($urandom);
        bad = 1'b0;
        for (int i = 1; i <= k; i++) begin
            tick();
            if (i < k && (rsp_valid !== 2'b00 || gnt !== 2'b00 || m_start !== 1'b0 || busy !== 1'b1 ||
                          m_rw !== e_rw || m_slave_sel !== e_sel || m_wdata !== e_w)) bad = 1'b1;
            if (i < k && d >= 0 && i == d + 1) begin
                m_done = 1'b1; m_nack = nack; m_rdata = rd;
            end else begin
                m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'($urandom);
            end
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s wait_phase: early response, stray pulse or unstable master fields, want quiet stable wait", tag);
        end
        n_tests++;
        if (rsp_valid !== oh || rsp_err !== e_err || rsp_rdata !== e_rd) begin
            n_fail++;
            $display("FAIL %s response: valid=%b err=%b rdata=%h, want valid=%b err=%b rdata=%h",
                     tag, rsp_valid, rsp_err, rsp_rdata, oh, e_err, e_rd);
        end
        m_done = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL %s back_to_idle: busy=%b valid=%b, want busy=0 valid=00", tag, busy, rsp_valid);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; m_done = 1'b0;
        tick();
        reset = 1'b0; ptr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b11; req_wdata0 = 8'hFF; req_wdata1 = 8'hFF; req_rw = 2'b11; req_sel = 2'b11;
        tick(); tick();
        n_tests++;
        if ({gnt, rsp_valid, rsp_err, rsp_rdata, m_start, m_rw, m_slave_sel, m_wdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b valid=%b err=%b rdata=%h start=%b rw=%b sel=%b wdata=%h busy=%b, want all 0",
                     gnt, rsp_valid, rsp_err, rsp_rdata, m_start, m_rw, m_slave_sel, m_wdata, busy);
        end
        req = 2'b00;
        reset = 1'b0; ptr = 1'b0;
    endtask

    task automatic test_single_write();
        run_txn(2'b01, 2'b00, 2'b00, 8'hA5, 8'h00, 3, 1'b0, 8'h77, 1'b0, "single_write");
    endtask

    task automatic test_read_slave2();
        run_txn(2'b10, 2'b10, 2'b10, 8'h11, 8'h22, 5, 1'b0, 8'h3C, 1'b0, "read_slave2");
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 2'b01, 2'b10, 8'hC0 + 8'(i), 8'hD0 + 8'(i), i, 1'b0, 8'h40 + 8'(i), 1'b1, "contention");
        req = 2'b00;
    endtask

    task automatic test_timeout();
        run_txn(2'b01, 2'b01, 2'b00, 8'h12, 8'h34, -1, 1'b0, 8'h99, 1'b0, "timeout");
        run_txn(2'b10, 2'b10, 2'b00, 8'h56, 8'h78, T - 1, 1'b0, 8'h5E, 1'b0, "timeout_tie_ack");
        run_txn(2'b01, 2'b00, 2'b01, 8'h9A, 8'hBC, T - 1, 1'b1, 8'h5E, 1'b0, "timeout_tie_nack");
    endtask

    task automatic test_nack_busy();
        logic bad;
        run_txn(2'b10, 2'b00, 2'b10, 8'h01, 8'h02, 2, 1'b1, 8'h00, 1'b0, "nack");
        m_busy = 1'b1; req = 2'b01; bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt !== 2'b00 || m_start !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL busy_gate: grant issued while m_busy=1, want gnt=00");
        end
        m_busy = 1'b0;
        run_txn(2'b01, 2'b01, 2'b01, 8'h0F, 8'hF0, 1, 1'b0, 8'hE7, 1'b0, "busy_release");
    endtask

    task automatic test_reset_in_wait();
        logic bad;
        req = 2'b01; req_rw = 2'b01; req_sel = 2'b01; req_wdata0 = 8'h5A;
        tick();
        req = 2'b00;
        tick(); tick();
        m_busy = 1'b1; reset = 1'b1; req = 2'b01;
        tick();
        n_tests++;
        if ({gnt, rsp_valid, rsp_err, rsp_rdata, m_start, m_rw, m_slave_sel, m_wdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_wait: gnt=%b valid=%b err=%b rdata=%h start=%b rw=%b sel=%b wdata=%h busy=%b, want all 0",
                     gnt, rsp_valid, rsp_err, rsp_rdata, m_start, m_rw, m_slave_sel, m_wdata, busy);
        end
        reset = 1'b0; ptr = 1'b0; bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_done = (i == 1); m_nack = 1'b1; m_rdata = 8'hFF;
            tick();
            if (gnt !== 2'b00 || m_start !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b0) bad = 1'b1;
        end
        m_done = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL stale_done_after_reset: activity seen while master busy, want none");
        end
        m_busy = 1'b0;
        run_txn(2'b01, 2'b01, 2'b00, 8'h33, 8'h44, 4, 1'b0, 8'hAB, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0] r;
        int         d;
        for (int n = 0; n < 30; n++) begin
            r = 2'($urandom_range(1, 3));
            d = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T - 1));
            run_txn(r, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), d,
                    1'($urandom), 8'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_slave2();
        test_contention();
        test_timeout();
        test_nack_busy();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
